// File: rtl/ins_fetch_pkg.sv
// Shared constants and buffer entry type for the instruction fetch stage.
package ins_fetch_pkg;

  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned FETCH_DEPTH    = 2;
  localparam int unsigned PC_INCR        = 4;
  localparam int unsigned PC_STORE_WIDTH = 32;
  localparam int unsigned CNT_WIDTH      = $clog2(FETCH_DEPTH + 1);

  // pc is stored at full width; the top truncates to ADDR_WIDTH on output
  typedef struct packed {
    logic [INSTR_WIDTH-1:0]    instr;
    logic [PC_STORE_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ins_fetch_fifo.sv
// Two-entry fetch buffer with flush and simultaneous push/pop; head always in slot 0.
module ins_fetch_fifo
  import ins_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  fetch_entry_t         push_entry,
  input  logic                 pop,
  output fetch_entry_t         head,
  output logic [CNT_WIDTH-1:0] count
);

  fetch_entry_t         entry_q [FETCH_DEPTH];
  fetch_entry_t         entry_d [FETCH_DEPTH];
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] wr_idx;
  logic                 do_pop;

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    wr_idx  = count_q - CNT_WIDTH'(do_pop);
    if (flush) begin
      count_d = '0;
    end else begin
      if (do_pop) begin
        entry_d[0] = entry_q[1];
      end
      // Issue logic never pushes into a full buffer, so wr_idx stays in range
      if (push) begin
        entry_d[wr_idx[0]] = push_entry;
      end
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '{default: '0};
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign head  = entry_q[0];
  assign count = count_q;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC, one-cycle memory read, 2-entry buffer to decode.
// Optional misaligned-redirect trap enabled by defining INS_FETCH_MISALIGN_TRAP_EN.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                   INS_FETCH_Clk,
  input  logic                   INS_FETCH_Reset,
  input  logic                   INS_FETCH_En,
  input  logic                   INS_FETCH_Redirect,
  input  logic [ADDR_WIDTH-1:0]  INS_FETCH_Redirect_Pc,
  output logic                   INS_FETCH_Mem_Re,
  output logic [ADDR_WIDTH-1:0]  INS_FETCH_Mem_Address,
  input  logic [INSTR_WIDTH-1:0] INS_FETCH_Mem_Data_In,
  output logic                   INS_FETCH_Out_Valid,
  input  logic                   INS_FETCH_Out_Ready,
  output logic [INSTR_WIDTH-1:0] INS_FETCH_Out_Instr,
  output logic [ADDR_WIDTH-1:0]  INS_FETCH_Out_Pc,
  output logic                   INS_FETCH_Misalign
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH:0]    occupancy;
  logic                  pop, push, issue;
  fetch_entry_t          head, push_entry;

  assign pop  = INS_FETCH_Out_Valid & INS_FETCH_Out_Ready;
  assign push = inflight_q & ~INS_FETCH_Redirect;

  // Slots committed after this cycle: buffered + in flight - popped now
  assign occupancy = {1'b0, count} + (CNT_WIDTH + 1)'(inflight_q) - (CNT_WIDTH + 1)'(pop);

  assign issue = INS_FETCH_En & ~INS_FETCH_Reset & ~INS_FETCH_Redirect & ~misalign_q
               & (occupancy < (CNT_WIDTH + 1)'(FETCH_DEPTH));

`ifdef INS_FETCH_MISALIGN_TRAP_EN
  assign target     = INS_FETCH_Redirect_Pc;
  assign misalign_d = misalign_q | (INS_FETCH_Redirect & (INS_FETCH_Redirect_Pc[1:0] != 2'b00));
`else
  assign target     = {INS_FETCH_Redirect_Pc[ADDR_WIDTH-1:2], 2'b00};
  assign misalign_d = 1'b0;
`endif

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (INS_FETCH_Redirect) begin
      pc_d = target;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_WIDTH'(PC_INCR);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge INS_FETCH_Clk) begin
    if (INS_FETCH_Reset) begin
      pc_q          <= ADDR_WIDTH'(RESET_PC);
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      misalign_q    <= misalign_d;
    end
  end

  assign push_entry = '{instr: INS_FETCH_Mem_Data_In, pc: PC_STORE_WIDTH'(inflight_pc_q)};

  ins_fetch_fifo u_fifo (
    .clk        (INS_FETCH_Clk),
    .reset      (INS_FETCH_Reset),
    .flush      (INS_FETCH_Redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign INS_FETCH_Mem_Re      = issue;
  assign INS_FETCH_Mem_Address = pc_q;
  assign INS_FETCH_Out_Valid   = (count != '0);
  assign INS_FETCH_Out_Instr   = head.instr;
  assign INS_FETCH_Out_Pc      = head.pc[ADDR_WIDTH-1:0];
  assign INS_FETCH_Misalign    = misalign_q;

endmodule
